// File: rtl/seven_segment_mux.sv
// Multiplexed hex driver for DIGITS seven-segment digits.
// Double-buffered data, LZS, DP/blank, PWM dimming, guard cycle.
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   EN            clock enable, everything holds when 0
//   DATA          one nibble per digit, digit 0 rightmost
//   DP, BLANK     per-digit decimal point / force dark
//   LOAD          capture DATA/DP/BLANK (applied at frame wrap)
//   LZS           leading-zero suppression enable
//   BRIGHT        PWM duty, 0 dark, all-ones full
//   SEGMENTS      a..g (bit0 = a), DP_OUT decimal point
//   SEL           one-hot digit select, FRAME wrap pulse
module seven_segment_mux #(
  parameter int DIGITS         = 4,
  parameter int THRESHOLD      = 100,
  parameter int BRIGHT_W       = 4,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     DP,
  input  logic [DIGITS-1:0]     BLANK,
  input  logic                  LOAD,
  input  logic                  LZS,
  input  logic [BRIGHT_W-1:0]   BRIGHT,
  output logic [6:0]            SEGMENTS,
  output logic                  DP_OUT,
  output logic [DIGITS-1:0]     SEL,
  output logic                  FRAME
);

  localparam int CW = $clog2(THRESHOLD + 1);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(THRESHOLD);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [BRIGHT_W-1:0] pwm;

  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0]   pend_dp, act_dp;
  logic [DIGITS-1:0]   pend_blank, act_blank;
  logic                pend;

  logic                slot_end;
  logic                wrap;
  logic                bright_on;
  logic                show;
  logic [DIGITS-1:0]   supp;
  logic                hz;
  logic [3:0]          nib;
  logic                dark;
  logic                dpv;
  logic [6:0]          seg_nx;
  logic                dp_nx;
  logic [DIGITS-1:0]   sel_nx;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt == '0);
  assign wrap      = slot_end && (idx == IDX_MAX);
  assign bright_on = (&BRIGHT) || (pwm < BRIGHT);
  // First cycle of every slot is a guard so the old digit's
  // segments never light the new digit.
  assign show      = (cnt != CNT_MAX) && bright_on;

  // A digit is suppressed when it and every digit above it is zero.
  always_comb begin
    hz   = 1'b1;
    supp = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hz      = hz & (act_data[4*k +: 4] == 4'h0);
      supp[k] = LZS && (k != 0) && hz;
    end
  end

  always_comb begin
    nib    = 4'h0;
    dark   = 1'b0;
    dpv    = 1'b0;
    sel_nx = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib       = act_data[4*k +: 4];
        dark      = act_blank[k] | supp[k];
        dpv       = act_dp[k];
        sel_nx[k] = show;
      end
    end
    seg_nx = dark ? 7'h00 : hex7(nib);
    dp_nx  = dark ? 1'b0 : dpv;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt        <= CNT_MAX;
      idx        <= '0;
      pwm        <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend       <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      SEGMENTS   <= {7{SEG_INV}};
      DP_OUT     <= SEG_INV;
      SEL        <= {DIGITS{SEL_INV}};
      FRAME      <= 1'b0;
    end else if (EN) begin
      pwm <= pwm + BRIGHT_W'(1);
      if (slot_end) begin
        cnt <= CNT_MAX;
        idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt - CW'(1);
      end
      FRAME <= wrap;
      // LOAD on the wrap edge goes straight to the active copy.
      if (wrap && LOAD) begin
        act_data  <= DATA;
        act_dp    <= DP;
        act_blank <= BLANK;
        pend      <= 1'b0;
      end else if (wrap && pend) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
        pend      <= 1'b0;
      end else if (LOAD) begin
        pend_data  <= DATA;
        pend_dp    <= DP;
        pend_blank <= BLANK;
        pend       <= 1'b1;
      end
      SEGMENTS <= seg_nx ^ {7{SEG_INV}};
      DP_OUT   <= dp_nx ^ SEG_INV;
      SEL      <= sel_nx ^ {DIGITS{SEL_INV}};
    end
  end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux (4 digits, slot 4, 2-bit PWM).
// Normal and fully inverted-polarity instances share stimulus.
module tb_seven_segment_mux;

  logic        CLK = 1'b0;
  logic        RST, EN, LOAD, LZS;
  logic [15:0] DATA;
  logic [3:0]  DP, BLANK;
  logic [1:0]  BRIGHT;
  logic [6:0]  seg, seg_n;
  logic        dpo, dpo_n;
  logic [3:0]  sel, sel_n;
  logic        frm, frm_n;

  int total = 0;
  int bad   = 0;

  localparam logic [12:0] INV = 13'b0_1111_1_1111111;

  always #5 CLK = ~CLK;

  seven_segment_mux #(
    .DIGITS(4), .THRESHOLD(3), .BRIGHT_W(2),
    .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DATA(DATA), .DP(DP),
    .BLANK(BLANK), .LOAD(LOAD), .LZS(LZS), .BRIGHT(BRIGHT),
    .SEGMENTS(seg), .DP_OUT(dpo), .SEL(sel), .FRAME(frm)
  );

  seven_segment_mux #(
    .DIGITS(4), .THRESHOLD(3), .BRIGHT_W(2),
    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut_n (
    .CLK(CLK), .RST(RST), .EN(EN), .DATA(DATA), .DP(DP),
    .BLANK(BLANK), .LOAD(LOAD), .LZS(LZS), .BRIGHT(BRIGHT),
    .SEGMENTS(seg_n), .DP_OUT(dpo_n), .SEL(sel_n), .FRAME(frm_n)
  );

  function automatic logic [12:0] obs();
    return {frm, sel, dpo, seg};
  endfunction

  function automatic logic [12:0] obs_n();
    return {frm_n, sel_n, dpo_n, seg_n};
  endfunction

  // Expected {FRAME,SEL,DP_OUT,SEGMENTS} for sample i (1..16)
  // after a FRAME sample; on[p] says whether SEL lights in
  // slot phase p (phase 0 is the guard cycle).
  function automatic logic [12:0] ev(int i, logic [27:0] segs,
                                     logic [3:0] dps,
                                     logic [3:0] on);
    int k = (i - 1) / 4;
    int p = (i - 1) % 4;
    logic [3:0] s = on[p] ? 4'(1 << k) : 4'b0000;
    return {(i == 16), s, dps[k], segs[7*k +: 7]};
  endfunction

  localparam logic [27:0] S1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
  localparam logic [27:0] SABCD = {7'h77, 7'h7C, 7'h39, 7'h5E};
  localparam logic [27:0] S5678 = {7'h6D, 7'h7D, 7'h07, 7'h7F};
  localparam logic [27:0] S0050 = {7'h00, 7'h00, 7'h6D, 7'h3F};
  localparam logic [27:0] S0000 = {7'h00, 7'h00, 7'h00, 7'h3F};
  localparam logic [27:0] SBLNK = {7'h00, 7'h5B, 7'h4F, 7'h66};
  localparam logic [27:0] SZERO = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
  localparam logic [3:0]  FULL  = 4'b1110;

  task automatic wait_frame(string name);
    bit seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge CLK);
      seen = frm;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s frame timeout got=0 want=1", name);
    end
  endtask

  task automatic pulse_load(logic [15:0] d);
    DATA = d;
    LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0; LOAD = 1'b1; LZS = 1'b0;
    DATA = 16'hFFFF; DP = 4'hF; BLANK = 4'h0; BRIGHT = 2'd3;
    repeat (3) @(negedge CLK);
    total++;
    if (obs() !== 13'h0) begin
      bad++;
      $display("FAIL reset got=%h want=%h", obs(), 13'h0);
    end
    total++;
    if (obs_n() !== INV) begin
      bad++;
      $display("FAIL reset_inv got=%h want=%h", obs_n(), INV);
    end
    RST = 1'b0; EN = 1'b1; LOAD = 1'b0; DP = 4'h0;
  endtask

  task automatic test_basic();
    pulse_load(16'h1234);
    wait_frame("basic");
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      total++;
      if (obs() !== ev(i, S1234, 4'h0, FULL)) begin
        bad++;
        $display("FAIL basic i=%0d got=%h want=%h",
                 i, obs(), ev(i, S1234, 4'h0, FULL));
      end
    end
  endtask

  task automatic test_midload();
    for (int j = 0; j < 48; j++) begin
      logic [27:0] s;
      int i = j % 16 + 1;
      s = (j < 16) ? S1234 : (j < 32) ? SABCD : S5678;
      @(negedge CLK);
      total++;
      if (obs() !== ev(i, s, 4'h0, FULL)) begin
        bad++;
        $display("FAIL midload j=%0d got=%h want=%h",
                 j, obs(), ev(i, s, 4'h0, FULL));
      end
      // mid-frame load, then a load landing on the wrap edge
      if (j == 4)  begin DATA = 16'hABCD; LOAD = 1'b1; end
      if (j == 30) begin DATA = 16'h5678; LOAD = 1'b1; end
      if (j == 5 || j == 31) LOAD = 1'b0;
    end
  endtask

  task automatic test_lzs();
    LZS = 1'b1;
    pulse_load(16'h0050);
    wait_frame("lzs");
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      total++;
      if (obs() !== ev(i, S0050, 4'h0, FULL)) begin
        bad++;
        $display("FAIL lzs_0050 i=%0d got=%h want=%h",
                 i, obs(), ev(i, S0050, 4'h0, FULL));
      end
    end
    pulse_load(16'h0000);
    wait_frame("lzs0");
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      total++;
      if (obs() !== ev(i, S0000, 4'h0, FULL)) begin
        bad++;
        $display("FAIL lzs_0000 i=%0d got=%h want=%h",
                 i, obs(), ev(i, S0000, 4'h0, FULL));
      end
    end
  endtask

  task automatic test_dp_blank();
    LZS = 1'b0; DP = 4'b1101; BLANK = 4'b1000;
    pulse_load(16'h1234);
    wait_frame("dp_blank");
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      total++;
      if (obs() !== ev(i, SBLNK, 4'b0101, FULL)) begin
        bad++;
        $display("FAIL dp_blank i=%0d got=%h want=%h",
                 i, obs(), ev(i, SBLNK, 4'b0101, FULL));
      end
    end
  endtask

  task automatic test_bright();
    // PWM and slot counter share phase: PWM==1 on slot phase 1.
    logic [1:0] br [3] = '{2'd2, 2'd1, 2'd0};
    logic [3:0] on [3] = '{4'b0010, 4'b0000, 4'b0000};
    for (int b = 0; b < 3; b++) begin
      BRIGHT = br[b];
      for (int i = 1; i <= 16; i++) begin
        @(negedge CLK);
        total++;
        if (obs() !== ev(i, SBLNK, 4'b0101, on[b])) begin
          bad++;
          $display("FAIL bright%0d i=%0d got=%h want=%h", br[b],
                   i, obs(), ev(i, SBLNK, 4'b0101, on[b]));
        end
      end
    end
    BRIGHT = 2'd3;
  endtask

  task automatic test_enable();
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      total++;
      if (obs() !== ev(i, SBLNK, 4'b0101, FULL)) begin
        bad++;
        $display("FAIL en_pre i=%0d got=%h want=%h",
                 i, obs(), ev(i, SBLNK, 4'b0101, FULL));
      end
    end
    EN = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      total++;
      if (obs() !== ev(6, SBLNK, 4'b0101, FULL)) begin
        bad++;
        $display("FAIL en_hold c=%0d got=%h want=%h",
                 c, obs(), ev(6, SBLNK, 4'b0101, FULL));
      end
      if (c == 2) begin DATA = 16'hFFFF; LOAD = 1'b1; end
      if (c == 3) LOAD = 1'b0;
    end
    EN = 1'b1;
    for (int j = 7; j <= 32; j++) begin
      int i = (j - 1) % 16 + 1;
      @(negedge CLK);
      total++;
      if (obs() !== ev(i, SBLNK, 4'b0101, FULL)) begin
        bad++;
        $display("FAIL en_resume j=%0d got=%h want=%h",
                 j, obs(), ev(i, SBLNK, 4'b0101, FULL));
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (7) @(negedge CLK);
    RST = 1'b1; LOAD = 1'b1; DATA = 16'h9999;
    @(negedge CLK);
    total++;
    if (obs() !== 13'h0) begin
      bad++;
      $display("FAIL rst_mid got=%h want=%h", obs(), 13'h0);
    end
    total++;
    if (obs_n() !== INV) begin
      bad++;
      $display("FAIL rst_mid_inv got=%h want=%h", obs_n(), INV);
    end
    RST = 1'b0; LOAD = 1'b0;
    wait_frame("rst_mid");
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      total++;
      if (obs() !== ev(i, SZERO, 4'h0, FULL)) begin
        bad++;
        $display("FAIL rst_nopend i=%0d got=%h want=%h",
                 i, obs(), ev(i, SZERO, 4'h0, FULL));
      end
      total++;
      if (obs_n() !== (ev(i, SZERO, 4'h0, FULL) ^ INV)) begin
        bad++;
        $display("FAIL rst_inv i=%0d got=%h want=%h",
                 i, obs_n(), ev(i, SZERO, 4'h0, FULL) ^ INV);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midload();
    test_lzs();
    test_dp_blank();
    test_bright();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
